// File: rtl/step_scheduler.sv
// Step sequencer: walks a 16-step pitch pattern, issues notes over valid/ready and drives gate/step_tick.
// Optional swing timing is enabled by defining SWING_EN.
module step_scheduler #(
    parameter int STEPS        = 16,
    parameter int PITCH_W      = 3,
    parameter int STEP_CYCLES  = 1_500_000,
    parameter int GATE_CYCLES  = 750_000,
    parameter int SWING_CYCLES = 250_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic [STEPS*PITCH_W-1:0]   beat_pitch,
    input  logic                       note_ready,
    output logic                       note_valid,
    output logic [PITCH_W-1:0]         note_pitch,
    output logic                       gate,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       step_tick,
    output logic                       overrun
);

    localparam int IDX_W  = $clog2(STEPS);
    localparam int CNT_W  = $clog2(STEP_CYCLES + SWING_CYCLES);
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [PITCH_W-1:0]  pitch_q, pitch_d;
    logic                gate_q, gate_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic                tick_q, tick_d;
    logic                overrun_q, overrun_d;
    logic                pend_q, pend_d;

    logic                handshake;
    logic                start;
    logic [IDX_W-1:0]    start_idx;
    logic [IDX_W-1:0]    next_idx;
    logic [PITCH_W-1:0]  new_pitch;
    logic [CNT_W-1:0]    last_cnt;

`ifdef SWING_EN
    // Even steps are stretched, odd steps shortened, so each pair keeps the nominal length.
    assign last_cnt = idx_q[0] ? CNT_W'(STEP_CYCLES - SWING_CYCLES - 1)
                               : CNT_W'(STEP_CYCLES + SWING_CYCLES - 1);
`else
    assign last_cnt = CNT_W'(STEP_CYCLES - 1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            pitch_q    <= '0;
            gate_q     <= 1'b0;
            gate_cnt_q <= '0;
            tick_q     <= 1'b0;
            overrun_q  <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            pitch_q    <= pitch_d;
            gate_q     <= gate_d;
            gate_cnt_q <= gate_cnt_d;
            tick_q     <= tick_d;
            overrun_q  <= overrun_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + CNT_W'(1);
        valid_d    = valid_q;
        pitch_d    = pitch_q;
        gate_d     = gate_q;
        gate_cnt_d = gate_cnt_q;
        tick_d     = 1'b0;
        overrun_d  = overrun_q;
        pend_d     = 1'b0;
        start      = 1'b0;
        start_idx  = idx_q;
        next_idx   = (idx_q == IDX_W'(STEPS - 1)) ? '0 : idx_q + IDX_W'(1);
        handshake  = valid_q && note_ready;

        if (gate_q) begin
            if (gate_cnt_q == '0) gate_d = 1'b0;
            else                  gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end

        if (handshake) begin
            valid_d    = 1'b0;
            state_d    = HOLD;
            gate_d     = 1'b1;
            gate_cnt_d = GATE_W'(GATE_CYCLES - 1);
        end

        if (state_q == IDLE) begin
            start     = run;
            start_idx = '0;
        end else if (pend_q) begin
            start = 1'b1;
        end else if (cnt_q == last_cnt) begin
            if (state_q == ISSUE && !handshake) begin
                // Dropped note: one idle gap cycle before the next step is evaluated.
                overrun_d = 1'b1;
                valid_d   = 1'b0;
                state_d   = HOLD;
                pend_d    = 1'b1;
                idx_d     = next_idx;
            end else begin
                start     = 1'b1;
                start_idx = next_idx;
            end
        end

        new_pitch = beat_pitch[int'(start_idx)*PITCH_W +: PITCH_W];

        if (start) begin
            idx_d   = start_idx;
            cnt_d   = '0;
            tick_d  = 1'b1;
            gate_d  = 1'b0;
            pitch_d = new_pitch;
            valid_d = (new_pitch != '0);
            state_d = (new_pitch != '0) ? ISSUE : HOLD;
        end

        if (!run) begin
            state_d    = IDLE;
            idx_d      = '0;
            cnt_d      = '0;
            valid_d    = 1'b0;
            pitch_d    = '0;
            gate_d     = 1'b0;
            gate_cnt_d = '0;
            tick_d     = 1'b0;
            pend_d     = 1'b0;
        end
    end

    assign note_valid = valid_q;
    assign note_pitch = pitch_q;
    assign gate       = gate_q;
    assign step_idx   = idx_q;
    assign step_tick  = tick_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: directed playback scenarios plus random traffic against a timeline model.
module tb_step_scheduler;

    localparam int STEPS        = 16;
    localparam int PITCH_W      = 3;
    localparam int STEP_CYCLES  = 8;
    localparam int GATE_CYCLES  = 3;
    localparam int SWING_CYCLES = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     run;
    logic [STEPS*PITCH_W-1:0] beat_pitch;
    logic                     note_ready;
    logic                     note_valid;
    logic [PITCH_W-1:0]       note_pitch;
    logic                     gate;
    logic [3:0]               step_idx;
    logic                     step_tick;
    logic                     overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    step_scheduler #(
        .STEPS(STEPS), .PITCH_W(PITCH_W), .STEP_CYCLES(STEP_CYCLES),
        .GATE_CYCLES(GATE_CYCLES), .SWING_CYCLES(SWING_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .beat_pitch(beat_pitch),
        .note_ready(note_ready), .note_valid(note_valid), .note_pitch(note_pitch),
        .gate(gate), .step_idx(step_idx), .step_tick(step_tick), .overrun(overrun)
    );

    // Reference timeline: which step is playing, how far into it, what note is owed.
    bit m_play, m_note, m_gap, m_tick, m_over;
    int m_step, m_t, m_pitch, m_gate_left;

    function automatic int step_len(input int s);
`ifdef SWING_EN
        return (s % 2 == 0) ? STEP_CYCLES + SWING_CYCLES : STEP_CYCLES - SWING_CYCLES;
`else
        return STEP_CYCLES;
`endif
    endfunction

    function automatic int pattern_at(input int s);
        logic [STEPS*PITCH_W-1:0] sh;
        sh = beat_pitch >> (s * PITCH_W);
        return int'(sh[PITCH_W-1:0]);
    endfunction

    task automatic begin_step(input int s);
        m_step = s; m_t = 0; m_gap = 0; m_gate_left = 0; m_tick = 1;
        m_pitch = pattern_at(s);
        m_note = (m_pitch != 0);
    endtask

    task automatic model_advance();
        bit accepted;
        m_tick = 0;
        if (!rst_n) begin
            m_play = 0; m_note = 0; m_gap = 0; m_over = 0;
            m_step = 0; m_t = 0; m_pitch = 0; m_gate_left = 0;
        end else if (!run) begin
            m_play = 0; m_note = 0; m_gap = 0;
            m_step = 0; m_t = 0; m_pitch = 0; m_gate_left = 0;
        end else if (!m_play) begin
            m_play = 1;
            begin_step(0);
        end else begin
            accepted = m_note && note_ready;
            if (m_gate_left > 0) m_gate_left--;
            if (accepted) begin
                m_note = 0;
                m_gate_left = GATE_CYCLES;
            end
            if (m_gap) begin
                begin_step(m_step);
            end else if (m_t == step_len(m_step) - 1) begin
                if (m_note) begin
                    m_over = 1; m_note = 0; m_gap = 1;
                    m_step = (m_step + 1) % STEPS;
                end else begin
                    begin_step((m_step + 1) % STEPS);
                end
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic compare_outputs();
        check("note_valid", 32'(note_valid), 32'(m_note));
        if (m_note || !m_play) check("note_pitch", 32'(note_pitch), 32'(m_pitch));
        check("gate", 32'(gate), 32'(m_gate_left > 0));
        check("step_idx", 32'(step_idx), 32'(m_step));
        check("step_tick", 32'(step_tick), 32'(m_tick));
        check("overrun", 32'(overrun), 32'(m_over));
    endtask

    task automatic drive_cycle(input logic rst_v, input logic run_v, input logic rdy_v);
        rst_n = rst_v; run = run_v; note_ready = rdy_v;
        model_advance();
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [STEPS*PITCH_W-1:0] fill_pattern(input int p);
        logic [STEPS*PITCH_W-1:0] v;
        for (int k = 0; k < STEPS; k++) v[k*PITCH_W +: PITCH_W] = PITCH_W'(p);
        return v;
    endfunction

    initial begin
        logic run_r;
        int waited;
        rst_n = 1'b0; run = 1'b0; note_ready = 1'b0;
        beat_pitch = fill_pattern(5);

        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0);

        // All pitches 5, always ready: full pass plus wrap.
        for (int i = 0; i < 150; i++) drive_cycle(1'b1, 1'b1, 1'b1);

        // Step 3 is a rest, others pitch 2.
        beat_pitch = fill_pattern(2);
        beat_pitch[3*PITCH_W +: PITCH_W] = '0;
        for (int i = 0; i < 150; i++) drive_cycle(1'b1, 1'b1, 1'b1);

        // Tone generator stalls for all of step 4: note dropped, overrun set.
        beat_pitch = fill_pattern(6);
        for (int i = 0; i < 150; i++) drive_cycle(1'b1, 1'b1, (m_step != 4));

        // Late accept near the end of each step truncates the gate.
        for (int i = 0; i < 150; i++) drive_cycle(1'b1, 1'b1, (m_t >= 6));

        // Stop while a note is pending, then reset and restart.
        waited = 0;
        drive_cycle(1'b1, 1'b1, 1'b0);
        while (!m_note && waited < 20) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            waited++;
        end
        check("pending_before_stop", 32'(note_valid), 32'd1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 1'b1, 1'b1);

        // Random traffic: patterns, stalls, stop/start and resets.
        run_r = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            if (i % 37 == 0)
                beat_pitch = (STEPS*PITCH_W)'({$urandom, $urandom});
            if ($urandom_range(0, 59) == 0) run_r = ~run_r;
            drive_cycle(($urandom_range(0, 299) != 0), run_r,
                        (i < 1200) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
